// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined adder/subtractor: operation mode and
// flag-vector layout.
package alu_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    localparam int FLG_S = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_C = 2;
    localparam int FLG_P = 3;
    localparam int FLG_V = 4;
    localparam int FLG_W = 5;

endpackage

// File: rtl/pipelined_addsub_flags_if.sv
// Operand/result handshake bundle between operand-fetch, the adder pipeline
// and writeback.
interface pipelined_addsub_flags_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Z;
    logic             Sign;
    logic             Zero;
    logic             Carry;
    logic             Parity;
    logic             Overflow;

    modport master (
        output in_valid, X, Y, sub, out_ready,
        input  in_ready, out_valid, Z, Sign, Zero, Carry, Parity, Overflow
    );

    modport slave (
        input  in_valid, X, Y, sub, out_ready,
        output in_ready, out_valid, Z, Sign, Zero, Carry, Parity, Overflow
    );

endinterface

// File: rtl/addsub_segment.sv
// SEG-bit ripple-carry adder built from a chain of full-adder cells; one
// instance per pipeline stage.
module addsub_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);

    logic c [0:SEG];

    assign c[0] = cin;

    for (genvar i = 0; i < SEG; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SEG];

endmodule

// File: rtl/pipelined_addsub_flags.sv
// WIDTH-bit add/subtract pipelined one SEG-bit segment per stage, with a
// single global advance so every stage shifts or holds together.
module pipelined_addsub_flags
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    pipelined_addsub_flags_if.slave   bus
);

    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;
    localparam int MSB    = WIDTH - 1;

    if ((WIDTH % SEG) != 0 || WIDTH < SEG) begin : g_bad_cfg
        $error("WIDTH must be a non-zero multiple of SEG");
    end

    logic                          adv;
    logic [STAGES-1:0]             vi;
    logic [STAGES-1:0]             ci;
    logic [STAGES-1:0]             co;
    logic [STAGES-1:0][WIDTH-1:0]  xi;
    logic [STAGES-1:0][WIDTH-1:0]  yi;
    logic [STAGES-1:0][WIDTH-1:0]  zi;
    logic [STAGES-1:0][WIDTH-1:0]  zd;

    logic [STAGES-1:0]             v_q;
    logic [STAGES-1:0]             c_q;
    logic [STAGES-1:0][WIDTH-1:0]  x_q;
    logic [STAGES-1:0][WIDTH-1:0]  y_q;
    logic [STAGES-1:0][WIDTH-1:0]  z_q;

    logic [FLG_W-1:0]              flg_d;
    logic [FLG_W-1:0]              flg_q;
    logic [WIDTH-1:0]              z_fin;

    assign adv = ~v_q[LAST] | bus.out_ready;

    // Stage 0 takes the bus operands with Y already inverted for subtract;
    // later stages take the previous stage's registered payload and carry.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0]   sum;
        logic [WIDTH-1:0] z_new;

        if (k == 0) begin : g_head
            assign xi[k] = bus.X;
            assign yi[k] = (bus.sub == MODE_SUB) ? ~bus.Y : bus.Y;
            assign zi[k] = '0;
            assign ci[k] = (bus.sub == MODE_SUB);
            assign vi[k] = bus.in_valid;
        end else begin : g_body
            assign xi[k] = x_q[k-1];
            assign yi[k] = y_q[k-1];
            assign zi[k] = z_q[k-1];
            assign ci[k] = c_q[k-1];
            assign vi[k] = v_q[k-1];
        end

        addsub_segment #(.SEG(SEG)) u_seg (
            .a    (xi[k][k*SEG +: SEG]),
            .b    (yi[k][k*SEG +: SEG]),
            .cin  (ci[k]),
            .s    (sum),
            .cout (co[k])
        );

        always_comb begin
            z_new                = zi[k];
            z_new[k*SEG +: SEG]  = sum;
        end

        assign zd[k] = z_new;
    end

    assign z_fin = zd[LAST];

    always_comb begin
        flg_d        = '0;
        flg_d[FLG_S] = z_fin[MSB];
        flg_d[FLG_Z] = ~|z_fin;
        flg_d[FLG_C] = co[LAST];
        flg_d[FLG_P] = ~^z_fin;
        flg_d[FLG_V] = (xi[LAST][MSB] == yi[LAST][MSB]) && (z_fin[MSB] != xi[LAST][MSB]);
    end

    // Payload only loads behind a valid token, so bubbles leave the last
    // result (and its flags) parked on the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            flg_q <= '0;
        end else if (adv) begin
            v_q <= vi;
            for (int k = 0; k < STAGES; k++) begin
                if (vi[k]) begin
                    x_q[k] <= xi[k];
                    y_q[k] <= yi[k];
                    z_q[k] <= zd[k];
                    c_q[k] <= co[k];
                end
            end
            if (vi[LAST]) begin
                flg_q <= flg_d;
            end
        end
    end

    logic unused_tail;
    assign unused_tail = ^{x_q[LAST], y_q[LAST], c_q[LAST]};

    assign bus.in_ready  = adv;
    assign bus.out_valid = v_q[LAST];
    assign bus.Z         = z_q[LAST];
    assign bus.Sign      = flg_q[FLG_S];
    assign bus.Zero      = flg_q[FLG_Z];
    assign bus.Carry     = flg_q[FLG_C];
    assign bus.Parity    = flg_q[FLG_P];
    assign bus.Overflow  = flg_q[FLG_V];

endmodule
